// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encodings and requester indices for spi_arbiter
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam int REQ_TINYPROG = 0;
    localparam int REQ_DFU      = 1;
    localparam int NUM_REQ      = 2;

endpackage

// File: rtl/spi_arb_pick.sv
// rtl/spi_arb_pick.sv - combinational 2-way tie-break producing a one-hot winner
module spi_arb_pick
    import spi_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] win
);

    always_comb begin
        win = '0;
        if (req[REQ_TINYPROG] && req[REQ_DFU]) begin
            // On a tie the requester that did not own the bus last time goes first.
            if ((FIXED_PRIO != 0) || (last == 1'b1)) begin
                win[REQ_TINYPROG] = 1'b1;
            end else begin
                win[REQ_DFU] = 1'b1;
            end
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - shares one SPI master between tinyprog (r0) and DFU (r1) per chip-select transaction
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [1:0]  req_en_i,
    input  logic [15:0] req_wr_data_i,
    input  logic [1:0]  req_wr_valid_i,
    output logic [1:0]  req_wr_ready_o,
    output logic [7:0]  req_rd_data_o,
    output logic [1:0]  req_rd_valid_o,
    input  logic [1:0]  req_rd_ready_i,
    output logic        spi_en_o,
    output logic [7:0]  spi_wr_data_o,
    output logic        spi_wr_valid_o,
    input  logic        spi_wr_ready_i,
    input  logic [7:0]  spi_rd_data_i,
    input  logic        spi_rd_valid_i,
    output logic        spi_rd_ready_o,
    input  logic        spi_csn_i,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       win;
    logic             sel;
    logic             owner_en;

    spi_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req  (req_en_i),
        .last (last_q),
        .win  (win)
    );

    assign sel      = grant_q[REQ_DFU];
    assign owner_en = |(grant_q & req_en_i);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        spi_en_o       = 1'b0;
        spi_wr_data_o  = 8'h00;
        spi_wr_valid_o = 1'b0;
        spi_rd_ready_o = 1'b0;
        req_wr_ready_o = 2'b00;
        req_rd_valid_o = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (|req_en_i) begin
                    grant_d = win;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                spi_en_o       = owner_en;
                spi_wr_data_o  = sel ? req_wr_data_i[15:8] : req_wr_data_i[7:0];
                spi_wr_valid_o = req_wr_valid_i[sel];
                spi_rd_ready_o = req_rd_ready_i[sel];
                req_wr_ready_o = grant_q & {2{spi_wr_ready_i}};
                req_rd_valid_o = grant_q & {2{spi_rd_valid_i}};
                if (!owner_en) begin
                    last_d  = sel;
                    grant_d = 2'b00;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Swallow any byte the master finishes after release so it cannot leak to the next owner.
                spi_rd_ready_o = 1'b1;
                if (spi_csn_i) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_o       = grant_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign req_rd_data_o = spi_rd_data_i;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench for spi_arbiter (dut a: round-robin gap 4, dut b: fixed prio gap 0)
module tb_spi_arbiter;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_en;
    logic [15:0] req_wr_data;
    logic [1:0]  req_wr_valid;
    logic [1:0]  req_rd_ready;
    logic        spi_wr_ready;
    logic [7:0]  spi_rd_data;
    logic        spi_rd_valid;
    logic        spi_csn;

    logic [1:0] a_req_wr_ready, a_req_rd_valid, a_grant;
    logic [7:0] a_req_rd_data, a_spi_wr_data;
    logic       a_spi_en, a_spi_wr_valid, a_spi_rd_ready, a_busy;
    logic [1:0] b_req_wr_ready, b_req_rd_valid, b_grant;
    logic [7:0] b_req_rd_data, b_spi_wr_data;
    logic       b_spi_en, b_spi_wr_valid, b_spi_rd_ready, b_busy;

    int checks = 0;
    int errors = 0;

    spi_arbiter #(.FIXED_PRIO(0), .GAP_CYCLES(4)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .req_en_i(req_en),
        .req_wr_data_i(req_wr_data), .req_wr_valid_i(req_wr_valid), .req_wr_ready_o(a_req_wr_ready),
        .req_rd_data_o(a_req_rd_data), .req_rd_valid_o(a_req_rd_valid), .req_rd_ready_i(req_rd_ready),
        .spi_en_o(a_spi_en), .spi_wr_data_o(a_spi_wr_data), .spi_wr_valid_o(a_spi_wr_valid),
        .spi_wr_ready_i(spi_wr_ready), .spi_rd_data_i(spi_rd_data), .spi_rd_valid_i(spi_rd_valid),
        .spi_rd_ready_o(a_spi_rd_ready), .spi_csn_i(spi_csn), .grant_o(a_grant), .busy_o(a_busy)
    );

    spi_arbiter #(.FIXED_PRIO(1), .GAP_CYCLES(0)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .req_en_i(req_en),
        .req_wr_data_i(req_wr_data), .req_wr_valid_i(req_wr_valid), .req_wr_ready_o(b_req_wr_ready),
        .req_rd_data_o(b_req_rd_data), .req_rd_valid_o(b_req_rd_valid), .req_rd_ready_i(req_rd_ready),
        .spi_en_o(b_spi_en), .spi_wr_data_o(b_spi_wr_data), .spi_wr_valid_o(b_spi_wr_valid),
        .spi_wr_ready_i(spi_wr_ready), .spi_rd_data_i(spi_rd_data), .spi_rd_valid_i(spi_rd_valid),
        .spi_rd_ready_o(b_spi_rd_ready), .spi_csn_i(spi_csn), .grant_o(b_grant), .busy_o(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: owner index (-1 = none), waiting-for-csn flag, and the first cycle a new arbitration may happen.
    int m_owner[2], m_drain[2], m_free[2], m_last[2];
    int m_fixed[2] = '{0, 1};
    int m_gap[2]   = '{4, 0};
    int mcyc = 0;
    int r1_wr_hs = 0, r1_rd_hs = 0;

    function automatic int winner(input logic [1:0] r, input int last, input int fixed);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        if (fixed != 0) return 0;
        return (last == 0) ? 1 : 0;
    endfunction

    task automatic model_cycle(input int k, input string tag,
                               input logic [1:0] g, input logic b, input logic en,
                               input logic [7:0] wd, input logic wv, input logic rr,
                               input logic [1:0] wrr, input logic [1:0] rdv, input logic [7:0] rd);
        int o;
        logic [1:0] oh;
        if (!rstn) begin
            m_owner[k] = -1; m_drain[k] = 0; m_free[k] = 0; m_last[k] = 1;
        end
        o  = m_owner[k];
        oh = (o >= 0) ? (2'b01 << o) : 2'b00;
        chk({tag, " grant"}, {30'd0, g}, {30'd0, oh});
        chk({tag, " busy"}, {31'd0, b}, {31'd0, (o >= 0 || m_drain[k] != 0 || mcyc < m_free[k])});
        chk({tag, " spi_en"}, {31'd0, en}, {31'd0, (o >= 0 && req_en[o])});
        chk({tag, " spi_wr_data"}, {24'd0, wd}, {24'd0, (o >= 0) ? req_wr_data[o*8 +: 8] : 8'h00});
        chk({tag, " spi_wr_valid"}, {31'd0, wv}, {31'd0, (o >= 0 && req_wr_valid[o])});
        chk({tag, " spi_rd_ready"}, {31'd0, rr}, {31'd0, (o >= 0) ? req_rd_ready[o] : (m_drain[k] != 0)});
        chk({tag, " req_wr_ready"}, {30'd0, wrr}, {30'd0, spi_wr_ready ? oh : 2'b00});
        chk({tag, " req_rd_valid"}, {30'd0, rdv}, {30'd0, spi_rd_valid ? oh : 2'b00});
        chk({tag, " req_rd_data"}, {24'd0, rd}, {24'd0, spi_rd_data});
        if (rstn) begin
            if (o >= 0) begin
                if (!req_en[o]) begin
                    m_last[k] = o; m_owner[k] = -1; m_drain[k] = 1;
                end
            end else if (m_drain[k] != 0) begin
                if (spi_csn) begin
                    m_drain[k] = 0;
                    m_free[k]  = mcyc + 1 + m_gap[k];
                end
            end else if (mcyc >= m_free[k] && req_en != 2'b00) begin
                m_owner[k] = winner(req_en, m_last[k], m_fixed[k]);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_cycle(0, "a", a_grant, a_busy, a_spi_en, a_spi_wr_data, a_spi_wr_valid,
                        a_spi_rd_ready, a_req_wr_ready, a_req_rd_valid, a_req_rd_data);
            model_cycle(1, "b", b_grant, b_busy, b_spi_en, b_spi_wr_data, b_spi_wr_valid,
                        b_spi_rd_ready, b_req_wr_ready, b_req_rd_valid, b_req_rd_data);
            if (rstn && req_wr_valid[1] && a_req_wr_ready[1]) r1_wr_hs++;
            if (rstn && req_rd_ready[1] && a_req_rd_valid[1]) r1_rd_hs++;
            mcyc++;
        end
    end

    logic [7:0] wbytes[4];
    logic [7:0] rbytes[4];

    initial begin
        wbytes[0] = 8'h03; wbytes[1] = 8'h00; wbytes[2] = 8'h00; wbytes[3] = 8'h00;
        rbytes[0] = 8'hA5; rbytes[1] = 8'h3C; rbytes[2] = 8'hFF; rbytes[3] = 8'h01;
        rstn = 1'b0; req_en = 2'b00; req_wr_data = 16'h0; req_wr_valid = 2'b00;
        req_rd_ready = 2'b00; spi_wr_ready = 1'b0; spi_rd_data = 8'h00;
        spi_rd_valid = 1'b0; spi_csn = 1'b1;
        repeat (3) step();
        chk("reset a grant", {30'd0, a_grant}, 32'd0);
        chk("reset a busy", {31'd0, a_busy}, 32'd0);
        chk("reset b spi_en", {31'd0, b_spi_en}, 32'd0);
        chk("reset a spi_rd_ready", {31'd0, a_spi_rd_ready}, 32'd0);
        rstn = 1'b1;
        step();

        // Single requester r1: 4 writes, 4 reads, r0 active but never granted.
        req_en = 2'b10; spi_csn = 1'b0; req_wr_valid = 2'b01; req_rd_ready = 2'b01;
        step();
        chk("t1 a grant", {30'd0, a_grant}, 32'h2);
        chk("t1 b grant", {30'd0, b_grant}, 32'h2);
        chk("t1 a spi_en", {31'd0, a_spi_en}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            req_wr_data = {wbytes[i], 8'h5A}; req_wr_valid = 2'b11; spi_wr_ready = 1'b1;
            #1;
            chk("t1 a spi_wr_data", {24'd0, a_spi_wr_data}, {24'd0, wbytes[i]});
            chk("t1 a req_wr_ready", {30'd0, a_req_wr_ready}, 32'h2);
            step();
        end
        req_wr_valid = 2'b01; spi_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spi_rd_valid = 1'b1; spi_rd_data = rbytes[i]; req_rd_ready = 2'b11;
            #1;
            chk("t1 a req_rd_valid", {30'd0, a_req_rd_valid}, 32'h2);
            chk("t1 a req_rd_data", {24'd0, a_req_rd_data}, {24'd0, rbytes[i]});
            step();
        end
        spi_rd_valid = 1'b0; spi_rd_data = 8'h00; req_rd_ready = 2'b01; req_wr_valid = 2'b00;
        req_en = 2'b00;
        #1;
        chk("t1 release spi_en same cycle", {31'd0, a_spi_en}, 32'd0);
        step();
        chk("t1 drain a busy", {31'd0, a_busy}, 32'h1);
        chk("t1 drain a grant", {30'd0, a_grant}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("t1 b held in drain", {31'd0, b_busy}, 32'h1);
            step();
        end
        spi_csn = 1'b1;
        step();
        chk("t1 b idle after csn", {31'd0, b_busy}, 32'd0);
        repeat (4) step();
        chk("t1 a idle after gap", {31'd0, a_busy}, 32'd0);
        chk("t1 r1 write handshakes", r1_wr_hs, 32'd4);
        chk("t1 r1 read handshakes", r1_rd_hs, 32'd4);

        // Tie: r0 first, r1 after release with gap, then r0 again.
        req_en = 2'b11; spi_csn = 1'b0;
        step();
        chk("t2 a tie r0", {30'd0, a_grant}, 32'h1);
        chk("t2 b tie r0", {30'd0, b_grant}, 32'h1);
        step();
        req_en = 2'b10;
        step();
        spi_csn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k <= 5) chk("t2 a spi_en low in gap", {31'd0, a_spi_en}, 32'd0);
            if (k == 2) chk("t2 b r1 grant", {30'd0, b_grant}, 32'h2);
            if (k == 6) chk("t2 a r1 grant at C+6", {30'd0, a_grant}, 32'h2);
        end
        spi_csn = 1'b0; req_en = 2'b11;
        step();
        req_en = 2'b01;
        step();
        req_en = 2'b11; spi_csn = 1'b1;
        step();
        step();
        chk("t2 b r0 regrant", {30'd0, b_grant}, 32'h1);
        repeat (4) step();
        chk("t2 a r0 on next tie", {30'd0, a_grant}, 32'h1);
        spi_csn = 1'b0;

        // Fixed priority: r0 keeps winning on b while r1 stays requesting.
        for (int i = 0; i < 3; i++) begin
            req_en = 2'b10;
            step();
            req_en = 2'b11; spi_csn = 1'b1;
            step();
            step();
            chk("t3 b r0 regranted", {30'd0, b_grant}, 32'h1);
            spi_csn = 1'b0;
        end

        // Asynchronous reset in the middle of a read.
        step();
        chk("t4 a owned by r1", {30'd0, a_grant}, 32'h2);
        spi_rd_valid = 1'b1; req_rd_ready = 2'b11;
        #1;
        chk("t4 a read valid pre-reset", {30'd0, a_req_rd_valid}, 32'h2);
        step();
        #2 rstn = 1'b0;
        #1;
        chk("t4 a grant async", {30'd0, a_grant}, 32'd0);
        chk("t4 b spi_en async", {31'd0, b_spi_en}, 32'd0);
        chk("t4 a rd_valid async", {30'd0, a_req_rd_valid}, 32'd0);
        chk("t4 a spi_rd_ready async", {31'd0, a_spi_rd_ready}, 32'd0);
        chk("t4 b busy async", {31'd0, b_busy}, 32'd0);
        repeat (2) step();
        spi_rd_valid = 1'b0; rstn = 1'b1;
        step();
        chk("t4 a first tie r0", {30'd0, a_grant}, 32'h1);
        chk("t4 b first tie r0", {30'd0, b_grant}, 32'h1);
        req_en = 2'b00; spi_csn = 1'b1;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
